// File: rtl/vliw_pkg.sv
// ============================================================================
// Module      : vliw_pkg
// Description : Shared constants, FSM state type and hazard helper for the
//               two-slot VLIW hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vliw_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 3;

    localparam logic [1:0] LAT_ALU  = 2'd1;
    localparam logic [1:0] LAT_LOAD = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // A branch compares in ID, so it must wait for any pending result;
    // ALU consumers only need to wait out the load-use slot.
    function automatic logic src_hazard(input logic [1:0] cnt, input logic is_branch);
        logic w_hz;
        w_hz = is_branch ? (cnt != 2'd0) : (cnt == LAT_LOAD);
        return w_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_counter.sv
// ============================================================================
// Module      : sb_counter
// Description : Per-register 2-bit ready counter: load on issue, otherwise
//               decrement to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_counter
    import vliw_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [1:0] i_load_val,
    output logic [1:0] o_cnt
);

    logic [1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_ctrl.sv
// ============================================================================
// Module      : hazard_scoreboard_ctrl
// Description : ID-stage hazard scoreboard for a two-slot VLIW bundle; stalls
//               load-use and branch-operand hazards, handles EX flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_ctrl #(
    parameter int NUM_REGS = vliw_pkg::NUM_REGS,
    parameter int REG_W    = vliw_pkg::REG_W,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] s0_src1,
    input  logic [REG_W-1:0] s0_src2,
    input  logic [REG_W-1:0] s0_dest,
    input  logic             s0_regwrite,
    input  logic             s0_memread,
    input  logic             s0_branch,
    input  logic [REG_W-1:0] s1_src1,
    input  logic [REG_W-1:0] s1_src2,
    input  logic [REG_W-1:0] s1_dest,
    input  logic             s1_regwrite,
    input  logic             s1_memread,
    input  logic             s1_branch,
    input  logic             ex_flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    import vliw_pkg::*;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_stall_cycles;
    logic [NUM_REGS-1:0][1:0] w_cnt;

    logic w_hz0;
    logic w_hz1;
    logic w_stall;
    logic w_kill;
    logic w_issue;
    logic w_in_flush;

    // ------------------------------------------------------------------
    // Ready counters; register 0 never carries a pending result
    // ------------------------------------------------------------------
    assign w_cnt[0] = 2'd0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
            logic       w_hit0;
            logic       w_hit1;
            logic       w_load;
            logic [1:0] w_load_val;

            assign w_hit0 = s0_regwrite && (s0_dest == REG_W'(r));
            assign w_hit1 = s1_regwrite && (s1_dest == REG_W'(r));
            assign w_load = w_issue && (w_hit0 || w_hit1);
            // Slot 1 is later in program order, so its latency wins on a tie
            assign w_load_val = w_hit1 ? (s1_memread ? LAT_LOAD : LAT_ALU)
                                       : (s0_memread ? LAT_LOAD : LAT_ALU);

            sb_counter u_cnt (
                .clk        (clk),
                .reset      (reset),
                .i_load     (w_load),
                .i_load_val (w_load_val),
                .o_cnt      (w_cnt[r])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard detection against pre-issue counters, so a slot 1 read of a
    // slot 0 destination sees the old value and never stalls.
    // ------------------------------------------------------------------
    always_comb begin
        w_hz0 = 1'b0;
        w_hz1 = 1'b0;
        if (s0_src1 != '0) w_hz0 = w_hz0 | src_hazard(w_cnt[s0_src1], s0_branch);
        if (s0_src2 != '0) w_hz0 = w_hz0 | src_hazard(w_cnt[s0_src2], s0_branch);
        if (s1_src1 != '0) w_hz1 = w_hz1 | src_hazard(w_cnt[s1_src1], s1_branch);
        if (s1_src2 != '0) w_hz1 = w_hz1 | src_hazard(w_cnt[s1_src2], s1_branch);
    end

    assign w_in_flush = (r_state == ST_FLUSH);
    assign w_kill     = ex_flush;
    assign w_stall    = id_valid && (w_hz0 || w_hz1) && !ex_flush && !w_in_flush && !reset;
    assign w_issue    = id_valid && !w_stall && !w_kill && !w_in_flush && !reset;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;

        if (ex_flush) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN, ST_STALL: w_state_nxt = w_stall ? ST_STALL : ST_RUN;
                ST_FLUSH:         w_state_nxt = ST_RUN;
                default:          w_state_nxt = ST_RUN;
            endcase
        end

        pc_write    = !w_stall;
        if_id_write = !w_stall;
        // While reset is held the FSM is forced to RUN, so only a missing
        // bundle produces a bubble.
        if (reset) begin
            id_ex_bubble = !id_valid;
        end else begin
            id_ex_bubble = w_stall || w_kill || !id_valid || w_in_flush;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_scoreboard_ctrl
// Description : Directed scoreboard bench for hazard_scoreboard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard_ctrl;

    localparam int REG_W = 3;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic [REG_W-1:0] dest;
        logic             rw;
        logic             mr;
        logic             br;
    } slot_t;

    typedef struct packed {
        logic             pc;
        logic             bub;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [REG_W-1:0] s0_src1, s0_src2, s0_dest;
    logic             s0_regwrite, s0_memread, s0_branch;
    logic [REG_W-1:0] s1_src1, s1_src2, s1_dest;
    logic             s1_regwrite, s1_memread, s1_branch;
    logic             ex_flush;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic [CNT_W-1:0] stall_cycles;

    exp_t             exp_q[$];
    string            tag_q[$];
    int               n_chk;
    int               n_err;
    logic [CNT_W-1:0] exp_sc;

    hazard_scoreboard_ctrl #(
        .NUM_REGS (8),
        .REG_W    (REG_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .s0_src1      (s0_src1),
        .s0_src2      (s0_src2),
        .s0_dest      (s0_dest),
        .s0_regwrite  (s0_regwrite),
        .s0_memread   (s0_memread),
        .s0_branch    (s0_branch),
        .s1_src1      (s1_src1),
        .s1_src2      (s1_src2),
        .s1_dest      (s1_dest),
        .s1_regwrite  (s1_regwrite),
        .s1_memread   (s1_memread),
        .s1_branch    (s1_branch),
        .ex_flush     (ex_flush),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_bubble (id_ex_bubble),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic slot_t nop();
        return '{src1: 3'd0, src2: 3'd0, dest: 3'd0, rw: 1'b0, mr: 1'b0, br: 1'b0};
    endfunction

    function automatic slot_t alu(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
        return '{src1: a, src2: b, dest: d, rw: 1'b1, mr: 1'b0, br: 1'b0};
    endfunction

    function automatic slot_t ld(input logic [2:0] d, input logic [2:0] a);
        return '{src1: a, src2: 3'd0, dest: d, rw: 1'b1, mr: 1'b1, br: 1'b0};
    endfunction

    function automatic slot_t br(input logic [2:0] a, input logic [2:0] b);
        return '{src1: a, src2: b, dest: 3'd0, rw: 1'b0, mr: 1'b0, br: 1'b1};
    endfunction

    task automatic check_outputs();
        exp_t  e;
        string t;
        n_chk++;
        assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty: got size %0d expected nonzero", exp_q.size());
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_chk++;
            assert (pc_write === e.pc) else begin
                n_err++;
                $error("FAIL %s pc_write: got %b expected %b", t, pc_write, e.pc);
            end
            n_chk++;
            assert (if_id_write === e.pc) else begin
                n_err++;
                $error("FAIL %s if_id_write: got %b expected %b", t, if_id_write, e.pc);
            end
            n_chk++;
            assert (id_ex_bubble === e.bub) else begin
                n_err++;
                $error("FAIL %s id_ex_bubble: got %b expected %b", t, id_ex_bubble, e.bub);
            end
            n_chk++;
            assert (stall_cycles === e.sc) else begin
                n_err++;
                $error("FAIL %s stall_cycles: got %0d expected %0d", t, stall_cycles, e.sc);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue the expected outputs, compare, and
    // advance the stall-count model past the clock edge.
    task automatic step(input string tag, input bit rst_i, input bit v,
                        input slot_t a, input slot_t b, input bit fl,
                        input bit e_stall, input bit e_bub);
        exp_t e;
        reset       = rst_i;
        id_valid    = v;
        s0_src1     = a.src1; s0_src2 = a.src2; s0_dest = a.dest;
        s0_regwrite = a.rw;   s0_memread = a.mr; s0_branch = a.br;
        s1_src1     = b.src1; s1_src2 = b.src2; s1_dest = b.dest;
        s1_regwrite = b.rw;   s1_memread = b.mr; s1_branch = b.br;
        ex_flush    = fl;
        e.pc  = ~e_stall;
        e.bub = e_bub;
        e.sc  = exp_sc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        check_outputs();
        if (rst_i) exp_sc = '0;
        else if (e_stall) exp_sc = exp_sc + 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, nop(), nop(), 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        exp_sc = '0;

        // Unchecked first reset edge brings the registers out of X
        reset = 1'b1; id_valid = 1'b0; ex_flush = 1'b0;
        s0_src1 = '0; s0_src2 = '0; s0_dest = '0; s0_regwrite = 1'b0; s0_memread = 1'b0; s0_branch = 1'b0;
        s1_src1 = '0; s1_src2 = '0; s1_dest = '0; s1_regwrite = 1'b0; s1_memread = 1'b0; s1_branch = 1'b0;
        @(negedge clk);

        step("rst_valid", 1'b1, 1'b1, nop(), nop(), 1'b0, 1'b0, 1'b0);
        step("rst_idle",  1'b1, 1'b0, nop(), nop(), 1'b0, 1'b0, 1'b1);
        idle("idle0");

        // Load then ALU consumer in slot 1: one stall
        step("ldu_ld",    1'b0, 1'b1, ld(3'd3, 3'd0), nop(),               1'b0, 1'b0, 1'b0);
        step("ldu_stall", 1'b0, 1'b1, nop(),          alu(3'd7, 3'd3, 3'd0), 1'b0, 1'b1, 1'b1);
        step("ldu_issue", 1'b0, 1'b1, nop(),          alu(3'd7, 3'd3, 3'd0), 1'b0, 1'b0, 1'b0);
        idle("ldu_cnt");
        idle("idle1");

        // ALU -> branch: one stall
        step("ab_alu",   1'b0, 1'b1, alu(3'd2, 3'd0, 3'd0), nop(), 1'b0, 1'b0, 1'b0);
        step("ab_stall", 1'b0, 1'b1, br(3'd2, 3'd0),        nop(), 1'b0, 1'b1, 1'b1);
        step("ab_issue", 1'b0, 1'b1, br(3'd2, 3'd0),        nop(), 1'b0, 1'b0, 1'b0);
        idle("idle2");
        idle("idle3");

        // Load -> branch: two stalls
        step("lb_ld",     1'b0, 1'b1, ld(3'd2, 3'd0), nop(), 1'b0, 1'b0, 1'b0);
        step("lb_stall1", 1'b0, 1'b1, br(3'd0, 3'd2), nop(), 1'b0, 1'b1, 1'b1);
        step("lb_stall2", 1'b0, 1'b1, br(3'd0, 3'd2), nop(), 1'b0, 1'b1, 1'b1);
        step("lb_issue",  1'b0, 1'b1, br(3'd0, 3'd2), nop(), 1'b0, 1'b0, 1'b0);
        idle("idle4");
        idle("idle5");

        // Intra-bundle reads of a slot 0 destination never stall
        step("ib_alu",  1'b0, 1'b1, alu(3'd4, 3'd0, 3'd0), alu(3'd5, 3'd4, 3'd0), 1'b0, 1'b0, 1'b0);
        step("ib_ldbr", 1'b0, 1'b1, ld(3'd3, 3'd0),        br(3'd3, 3'd0),        1'b0, 1'b0, 1'b0);
        idle("idle6");
        idle("idle7");

        // Flush overrides a load-use stall; counters keep draining in FLUSH
        step("fl_ld",    1'b0, 1'b1, ld(3'd5, 3'd0),        nop(), 1'b0, 1'b0, 1'b0);
        step("fl_kill",  1'b0, 1'b1, alu(3'd6, 3'd5, 3'd0), nop(), 1'b1, 1'b0, 1'b1);
        step("fl_state", 1'b0, 1'b1, alu(3'd6, 3'd5, 3'd0), nop(), 1'b0, 1'b0, 1'b1);
        step("fl_run",   1'b0, 1'b1, alu(3'd6, 3'd5, 3'd0), nop(), 1'b0, 1'b0, 1'b0);
        idle("idle8");
        idle("idle9");

        // r0 never becomes pending; same-dest bundle takes slot 1 latency
        step("r0_ld",    1'b0, 1'b1, ld(3'd0, 3'd0),        nop(),                 1'b0, 1'b0, 1'b0);
        step("r0_br",    1'b0, 1'b1, br(3'd0, 3'd0),        alu(3'd1, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        step("dd_issue", 1'b0, 1'b1, ld(3'd6, 3'd0),        alu(3'd6, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        step("dd_alu",   1'b0, 1'b1, alu(3'd7, 3'd6, 3'd0), nop(),                 1'b0, 1'b0, 1'b0);
        idle("idle10");
        idle("idle11");
        step("dd2_issue", 1'b0, 1'b1, ld(3'd6, 3'd0), alu(3'd6, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        step("dd2_stall", 1'b0, 1'b1, br(3'd6, 3'd0), nop(),                 1'b0, 1'b1, 1'b1);
        step("dd2_go",    1'b0, 1'b1, br(3'd6, 3'd0), nop(),                 1'b0, 1'b0, 1'b0);
        idle("idle12");
        idle("idle13");

        // An invalid bundle never stalls even with a pending operand
        step("nv_ld",    1'b0, 1'b1, ld(3'd3, 3'd0), nop(),                 1'b0, 1'b0, 1'b0);
        step("nv_inval", 1'b0, 1'b0, nop(),          alu(3'd7, 3'd3, 3'd0), 1'b0, 1'b0, 1'b1);
        step("nv_valid", 1'b0, 1'b1, nop(),          alu(3'd7, 3'd3, 3'd0), 1'b0, 1'b0, 1'b0);
        idle("idle14");
        idle("idle15");

        // Reset in the middle of a load -> branch stall
        step("rs_ld",    1'b0, 1'b1, ld(3'd2, 3'd0), nop(), 1'b0, 1'b0, 1'b0);
        step("rs_stall", 1'b0, 1'b1, br(3'd2, 3'd0), nop(), 1'b0, 1'b1, 1'b1);
        step("rs_reset", 1'b1, 1'b1, br(3'd2, 3'd0), nop(), 1'b0, 1'b0, 1'b0);
        step("rs_after", 1'b0, 1'b1, br(3'd2, 3'd0), nop(), 1'b0, 1'b0, 1'b0);
        idle("rs_idle");

        n_chk++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
